// File: rtl/data_mem_pkg.sv
// data_mem_pkg
// Shared types and helpers for the MEM-stage data memory controller.
//   size_e       : access size encoding carried on req_size
//   state_e      : controller state (CLEAR only used when
//                  DATA_MEM_INIT_CLEAR_EN is defined)
//   byte_enables : per-byte write lanes for a given size and lane offset
package data_mem_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } size_e;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    // Returns an 8-lane enable mask; callers truncate to their word width.
    // The base pattern covers (1 << size) bytes and is moved up by lane.
    function automatic logic [7:0] byte_enables(input size_e size, input logic [2:0] lane);
        logic [7:0] base;
        case (size)
            SZ_B:    base = 8'h01;
            SZ_H:    base = 8'h03;
            SZ_W:    base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << lane;
    endfunction

endpackage

// File: rtl/data_mem_if.sv
// data_mem_if
// Request/response bundle between the pipeline MEM stage and the data memory.
//   req_valid/req_ready : request handshake, accepted when both are high
//   req_write           : 1 = store, 0 = load
//   req_addr            : byte address
//   req_size            : 00 byte, 01 half, 10 word, 11 dword
//   req_unsigned        : zero-extend loads when set
//   req_wdata           : right-justified store data
//   rsp_valid           : single-cycle response pulse
//   rsp_rdata           : extended load data, 0 for stores and faults
//   rsp_fault           : misaligned, out of range, or illegal size
// Modports: master drives requests, slave (the memory) drives responses.
interface data_mem_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_fault;

    modport master (
        output req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault
    );

endinterface

// File: rtl/data_mem_load_align.sv
// data_mem_load_align
// Combinational load formatter: takes the full registered memory word and
// produces the right-justified, size-masked and extended load result.
//   word     : raw memory word read on the accept edge
//   lane     : byte offset of the access inside the word
//   size     : access size (size_e)
//   zero_ext : zero-extend when set, sign-extend otherwise
//   out      : formatted load data
module data_mem_load_align
    import data_mem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]             word,
    input  logic [$clog2(DATA_W/8)-1:0]   lane,
    input  size_e                         size,
    input  logic                          zero_ext,
    output logic [DATA_W-1:0]             out
);

    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] top_bit;
    logic              full;
    logic              sign;
    int                nbits;

    // The sign bit is located as the highest set bit of the size mask, which
    // avoids a variable index that could run past the word for full-width
    // accesses. Full-width loads never extend, so req_unsigned is moot there.
    always_comb begin
        shifted = word >> {lane, 3'b000};
        nbits   = 8 << size;
        full    = (nbits >= DATA_W);
        mask    = full ? '1 : ~({DATA_W{1'b1}} << nbits);
        top_bit = mask ^ (mask >> 1);
        sign    = |(shifted & top_bit);
        out     = shifted & mask;
        if (!zero_ext && !full && sign) begin
            out = out | ~mask;
        end
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl
// Byte-addressable data memory for the pipeline MEM stage. Loads and stores
// of byte/half/word (and dword when DATA_W=64) with one-cycle response.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : data_mem_if slave modport (request handshake + response)
// Optional build macro DATA_MEM_INIT_CLEAR_EN: after reset the controller
// walks every word writing zero and holds req_ready low until done. Without
// it the array is plain RAM with undefined power-up contents.
module data_mem_ctrl
    import data_mem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 1024
) (
    input  logic      clk,
    input  logic      reset_n,
    data_mem_if.slave bus
);

    localparam int BYTES  = DATA_W / 8;
    localparam int LANE_W = $clog2(BYTES);
    localparam int IDX_W  = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W + 1)'(DEPTH_WORDS * BYTES);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    logic [LANE_W-1:0] lane;
    logic [IDX_W-1:0]  idx;
    size_e             size;
    logic [LANE_W-1:0] align_mask;
    logic              misaligned;
    logic              out_of_range;
    logic              bad_size;
    logic              fault;
    logic              accept;
    logic [BYTES-1:0]  be;
    logic [DATA_W-1:0] wdata_shift;

    state_e            state;
    logic              ready_q;

    logic              rsp_valid_q;
    logic              rsp_fault_q;
    logic              ld_pending;
    logic [LANE_W-1:0] ld_lane;
    size_e             ld_size;
    logic              ld_zext;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] aligned;

    // Request decode. The word index deliberately ignores address bits above
    // the array, so out-of-range requests must be stopped by the fault flag
    // before they can alias onto a low word.
    always_comb begin
        lane         = bus.req_addr[LANE_W-1:0];
        idx          = bus.req_addr[LANE_W +: IDX_W];
        size         = size_e'(bus.req_size);
        align_mask   = LANE_W'((4'd1 << bus.req_size) - 4'd1);
        misaligned   = |(lane & align_mask);
        out_of_range = ({1'b0, bus.req_addr} >= MEM_BYTES);
        bad_size     = (DATA_W == 32) && (size == SZ_D);
        fault        = misaligned || out_of_range || bad_size;
        accept       = bus.req_valid && ready_q;
        be           = BYTES'(byte_enables(size, 3'(lane)));
        wdata_shift  = bus.req_wdata << {lane, 3'b000};
    end

`ifdef DATA_MEM_INIT_CLEAR_EN
    logic [IDX_W-1:0] clear_cnt;

    // Controller FSM: after reset, sweep one word per cycle, then open the
    // request port. Any reset restarts the sweep from word 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= CLEAR;
            clear_cnt <= '0;
            ready_q   <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    clear_cnt <= clear_cnt + 1'b1;
                    if (clear_cnt == IDX_W'(DEPTH_WORDS - 1)) begin
                        state   <= READY;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Storage array. Kept free of reset so it maps onto RAM; the clear sweep
    // and request writes never overlap because req_ready is low while clearing.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clear_cnt] <= '0;
        end else if (accept && bus.req_write && !fault) begin
            for (int b = 0; b < BYTES; b++) begin
                if (be[b]) begin
                    mem[idx][b*8 +: 8] <= wdata_shift[b*8 +: 8];
                end
            end
        end
        if (accept && !bus.req_write) begin
            rd_word <= mem[idx];
        end
    end
`else
    // Controller FSM: only READY exists; req_ready comes up at the first edge
    // after reset is released.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= READY;
            ready_q <= 1'b0;
        end else begin
            case (state)
                READY:   ready_q <= 1'b1;
                default: ready_q <= 1'b1;
            endcase
        end
    end

    // Storage array with byte-lane writes and a registered full-word read.
    always_ff @(posedge clk) begin
        if (accept && bus.req_write && !fault) begin
            for (int b = 0; b < BYTES; b++) begin
                if (be[b]) begin
                    mem[idx][b*8 +: 8] <= wdata_shift[b*8 +: 8];
                end
            end
        end
        if (accept && !bus.req_write) begin
            rd_word <= mem[idx];
        end
    end
`endif

    // Response tracking: every accepted request yields one pulse next cycle.
    // Load formatting info rides alongside the raw word so the shift/extend
    // happens in the response cycle. Reset drops any in-flight response.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid_q <= 1'b0;
            rsp_fault_q <= 1'b0;
            ld_pending  <= 1'b0;
            ld_lane     <= '0;
            ld_size     <= SZ_B;
            ld_zext     <= 1'b0;
        end else begin
            rsp_valid_q <= accept;
            rsp_fault_q <= accept && fault;
            ld_pending  <= accept && !bus.req_write && !fault;
            if (accept) begin
                ld_lane <= lane;
                ld_size <= size;
                ld_zext <= bus.req_unsigned;
            end
        end
    end

    data_mem_load_align #(
        .DATA_W (DATA_W)
    ) u_load_align (
        .word     (rd_word),
        .lane     (ld_lane),
        .size     (ld_size),
        .zero_ext (ld_zext),
        .out      (aligned)
    );

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_fault = rsp_fault_q;
    assign bus.rsp_rdata = ld_pending ? aligned : '0;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl
// Self-checking bench for data_mem_ctrl (DATA_W=32, DEPTH_WORDS=1024).
// A byte-array reference model predicts every response and the req_ready
// level; directed stimulus adds literal expectations at key points.
// Behaviour under DATA_MEM_INIT_CLEAR_EN is selected by the same macro.
module tb_data_mem_ctrl;

    import data_mem_pkg::*;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 32;
    localparam int DEPTH     = 1024;
    localparam int BYTES     = DATA_W / 8;
    localparam int MEM_BYTES = DEPTH * BYTES;
`ifdef DATA_MEM_INIT_CLEAR_EN
    localparam bit CLEAR_EN  = 1'b1;
`else
    localparam bit CLEAR_EN  = 1'b0;
`endif
    localparam int READY_LAT = CLEAR_EN ? DEPTH : 1;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    int   tests_run    = 0;
    int   tests_failed = 0;

    data_mem_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    data_mem_ctrl #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .DEPTH_WORDS (DEPTH)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [7:0]        model_mem   [MEM_BYTES];
    bit                model_known [MEM_BYTES];
    int                edge_cnt  = 0;
    bit                exp_valid = 1'b0;
    bit                exp_fault = 1'b0;
    bit                exp_known = 1'b1;
    logic [DATA_W-1:0] exp_rdata = '0;

    function automatic void check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endfunction

    // Memory after reset: zero when the clear sweep exists, unknown otherwise.
    function automatic void model_reset();
        for (int i = 0; i < MEM_BYTES; i++) begin
            if (CLEAR_EN) model_mem[i] = 8'h00;
            model_known[i] = CLEAR_EN;
        end
        edge_cnt  = 0;
        exp_valid = 1'b0;
        exp_fault = 1'b0;
        exp_known = 1'b1;
        exp_rdata = '0;
    endfunction

    // One rising edge of the reference: accept, fault, store or load.
    function automatic void model_step();
        bit            acc;
        int            nb;
        longint        a;
        logic [63:0]   value;
        acc = bus.req_valid && (edge_cnt >= READY_LAT);
        if (edge_cnt < 1000000) edge_cnt++;
        exp_valid = acc;
        exp_fault = 1'b0;
        exp_known = 1'b1;
        exp_rdata = '0;
        if (!acc) return;
        nb = 1 << bus.req_size;
        a  = longint'(bus.req_addr);
        if ((a % nb) != 0 || a >= MEM_BYTES || (bus.req_size == 2'b11 && DATA_W == 32)) begin
            exp_fault = 1'b1;
            return;
        end
        if (bus.req_write) begin
            for (int i = 0; i < nb; i++) begin
                model_mem[int'(a) + i]   = bus.req_wdata[8*i +: 8];
                model_known[int'(a) + i] = 1'b1;
            end
        end else begin
            value = '0;
            for (int i = 0; i < nb; i++) begin
                if (!model_known[int'(a) + i]) exp_known = 1'b0;
                value[8*i +: 8] = model_mem[int'(a) + i];
            end
            if (!bus.req_unsigned && nb < BYTES && value[8*nb-1]) begin
                for (int k = 8 * nb; k < 64; k++) value[k] = 1'b1;
            end
            exp_rdata = value[DATA_W-1:0];
        end
    endfunction

    // Compare process: model advances on each rising edge, outputs are
    // checked on the following falling edge.
    initial begin : compare_proc
        forever begin
            @(posedge clk);
            if (!reset_n) model_reset();
            else          model_step();
            @(negedge clk);
            if (!reset_n) begin
                exp_valid = 1'b0;
                check("ready_in_reset", 64'(bus.req_ready), 64'(0));
                check("valid_in_reset", 64'(bus.rsp_valid), 64'(0));
            end else begin
                check("model_ready", 64'(bus.req_ready), 64'(edge_cnt >= READY_LAT));
                check("model_rsp_valid", 64'(bus.rsp_valid), 64'(exp_valid));
                if (exp_valid) begin
                    check("model_rsp_fault", 64'(bus.rsp_fault), 64'(exp_fault));
                    if (exp_known) check("model_rsp_rdata", 64'(bus.rsp_rdata), 64'(exp_rdata));
                end
            end
        end
    end

    // Drives one request starting at a falling edge; returns at the next
    // falling edge, when its response is visible.
    task automatic apply_stimulus(input bit wr, input logic [ADDR_W-1:0] addr, input logic [1:0] size,
                                  input bit uns, input logic [DATA_W-1:0] wdata);
        bus.req_valid    = 1'b1;
        bus.req_write    = wr;
        bus.req_addr     = addr;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_wdata    = wdata;
        @(negedge clk);
        bus.req_valid    = 1'b0;
        bus.req_write    = 1'b0;
    endtask

    task automatic check_output(input string name, input logic [DATA_W-1:0] rdata, input bit fault);
        check({name, "_valid"}, 64'(bus.rsp_valid), 64'(1));
        check({name, "_rdata"}, 64'(bus.rsp_rdata), 64'(rdata));
        check({name, "_fault"}, 64'(bus.rsp_fault), 64'(fault));
    endtask

    // Counts falling edges from reset release until req_ready is seen high.
    task automatic measure_ready(input string name);
        int cyc;
        cyc = 0;
        while (bus.req_ready !== 1'b1 && cyc < DEPTH + 20) begin
            @(negedge clk);
            cyc++;
        end
        check(name, 64'(cyc), 64'(READY_LAT));
    endtask

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        bus.req_valid    = 1'b0;
        bus.req_write    = 1'b0;
        bus.req_addr     = '0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_wdata    = '0;

        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ready", 64'(bus.req_ready), 64'(0));
        check("reset_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        check("reset_rsp_rdata", 64'(bus.rsp_rdata), 64'(0));
        check("reset_rsp_fault", 64'(bus.rsp_fault), 64'(0));
        reset_n = 1'b1;
        measure_ready("ready_latency");

`ifndef DATA_MEM_INIT_CLEAR_EN
        // Plain RAM: give the words used below a known zero value first.
        for (int w = 0; w < 16; w++) apply_stimulus(1'b1, ADDR_W'(w * 4), 2'b10, 1'b0, '0);
        apply_stimulus(1'b1, 32'hFFC, 2'b10, 1'b0, '0);
`endif
        apply_stimulus(1'b0, 32'h3C, 2'b10, 1'b0, '0);
        check_output("lw_3c_zero", 32'h0000_0000, 1'b0);

        apply_stimulus(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF);
        check_output("sw_10", 32'h0, 1'b0);
        apply_stimulus(1'b0, 32'h10, 2'b10, 1'b0, '0);
        check_output("lw_10_after_sw", 32'hDEADBEEF, 1'b0);
        apply_stimulus(1'b0, 32'h10, 2'b10, 1'b1, '0);
        check_output("lwu_10_full_width", 32'hDEADBEEF, 1'b0);

        apply_stimulus(1'b1, 32'h21, 2'b00, 1'b0, 32'h0000_0080);
        check_output("sb_21", 32'h0, 1'b0);
        apply_stimulus(1'b0, 32'h21, 2'b00, 1'b0, '0);
        check_output("lb_21", 32'hFFFF_FF80, 1'b0);
        apply_stimulus(1'b0, 32'h21, 2'b00, 1'b1, '0);
        check_output("lbu_21", 32'h0000_0080, 1'b0);
        apply_stimulus(1'b0, 32'h20, 2'b10, 1'b0, '0);
        check_output("lw_20", 32'h0000_8000, 1'b0);

        apply_stimulus(1'b1, 32'h30, 2'b10, 1'b0, 32'h7FFF_8001);
        check_output("sw_30", 32'h0, 1'b0);
        apply_stimulus(1'b0, 32'h32, 2'b01, 1'b1, '0);
        check_output("lhu_32", 32'h0000_7FFF, 1'b0);
        apply_stimulus(1'b0, 32'h30, 2'b01, 1'b0, '0);
        check_output("lh_30", 32'hFFFF_8001, 1'b0);
        apply_stimulus(1'b0, 32'h32, 2'b01, 1'b0, '0);
        check_output("lh_32", 32'h0000_7FFF, 1'b0);
        apply_stimulus(1'b0, 32'h30, 2'b01, 1'b1, '0);
        check_output("lhu_30", 32'h0000_8001, 1'b0);

        // Halfword store must ignore the upper bits of its data.
        apply_stimulus(1'b1, 32'h16, 2'b01, 1'b0, 32'hFFFF_BEEF);
        check_output("sh_16", 32'h0, 1'b0);
        apply_stimulus(1'b0, 32'h14, 2'b10, 1'b0, '0);
        check_output("lw_14", 32'hBEEF_0000, 1'b0);

        apply_stimulus(1'b0, 32'h11, 2'b01, 1'b0, '0);
        check_output("lh_11_misaligned", 32'h0, 1'b1);
        apply_stimulus(1'b0, 32'h02, 2'b10, 1'b0, '0);
        check_output("lw_02_misaligned", 32'h0, 1'b1);
        apply_stimulus(1'b0, 32'h00, 2'b11, 1'b0, '0);
        check_output("ld_00_bad_size", 32'h0, 1'b1);

        apply_stimulus(1'b1, 32'h00, 2'b10, 1'b0, 32'h1234_5678);
        check_output("sw_00", 32'h0, 1'b0);
        apply_stimulus(1'b1, 32'h1000, 2'b10, 1'b0, 32'hAAAA_AAAA);
        check_output("sw_1000_range", 32'h0, 1'b1);
        apply_stimulus(1'b0, 32'h00, 2'b10, 1'b0, '0);
        check_output("lw_00_unchanged", 32'h1234_5678, 1'b0);

        apply_stimulus(1'b1, 32'hFFF, 2'b00, 1'b0, 32'h0000_005A);
        check_output("sb_fff_last", 32'h0, 1'b0);
        apply_stimulus(1'b0, 32'hFFF, 2'b00, 1'b1, '0);
        check_output("lbu_fff_last", 32'h0000_005A, 1'b0);
        apply_stimulus(1'b0, 32'hFFC, 2'b10, 1'b0, '0);
        check_output("lw_ffc", 32'h5A00_0000, 1'b0);

        // Reset with a load in flight: its response must never appear.
        bus.req_valid    = 1'b1;
        bus.req_write    = 1'b0;
        bus.req_addr     = 32'h10;
        bus.req_size     = 2'b10;
        bus.req_unsigned = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("dropped_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

`ifdef DATA_MEM_INIT_CLEAR_EN
        // Interrupt the sweep at count 5; it must restart from word 0.
        repeat (5) @(posedge clk);
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        measure_ready("ready_after_mid_clear");
        apply_stimulus(1'b0, 32'h10, 2'b10, 1'b0, '0);
        check_output("lw_10_recleared", 32'h0, 1'b0);
        apply_stimulus(1'b0, 32'h00, 2'b10, 1'b0, '0);
        check_output("lw_00_recleared", 32'h0, 1'b0);
`else
        measure_ready("ready_after_reset");
        apply_stimulus(1'b0, 32'h10, 2'b10, 1'b0, '0);
        check("post_reset_valid", 64'(bus.rsp_valid), 64'(1));
        check("post_reset_fault", 64'(bus.rsp_fault), 64'(0));
`endif

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Parametrised byte-addressable data memory for the MEM stage of the 5-stage RISC-V pipeline. It supports byte, halfword and word (and doubleword when DATA_W=64) loads and stores through per-byte lane enables, with sign or zero extension on loads. Reads are synchronous with a registered response. Misaligned and out-of-range accesses are reported as faults for the pipeline's trap logic.

## Interface
- DATA_W, 32, memory word width; 32 or 64 only
- ADDR_W, 32, byte-address width
- DEPTH_WORDS, 1024, number of words; power of two
- clk  in  1  single clock; all state updates on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_write  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  byte address
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = dword (legal only when DATA_W=64)
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- req_wdata  in  DATA_W  store data, right-justified
- rsp_valid  out  1  one-cycle pulse; response for the accepted request
- rsp_rdata  out  DATA_W  extended load data; 0 for stores and faults
- rsp_fault  out  1  request was misaligned, out of range, or used an illegal size

## Operation
- Accept: req_valid && req_ready at a rising edge. One request per cycle; the block has no internal queue.
- BYTES = DATA_W/8. word index = req_addr[log2(BYTES) +: log2(DEPTH_WORDS)]; lane = req_addr[log2(BYTES)-1:0].
- Fault conditions: lane not a multiple of (1<<req_size); req_addr ≥ DEPTH_WORDS*BYTES; req_size=11 with DATA_W=32.
- On a faulting store, memory is unchanged.
- Store: byte enables = ((1<<(1<<size))-1) << lane. req_wdata is shifted left by lane*8. Only enabled bytes are written.
- Load:
  - Read the full word and register it with size, lane and unsigned flag.
  - Next cycle, shift right by lane*8 and mask to the access size.
  - Sign-extend from the top bit of the access unless req_unsigned is set.
  - req_unsigned is ignored for full-width loads.
- Every accepted request produces exactly one rsp_valid pulse.
- State machine:
  - CLEAR: only with the configuration macro defined. Counter walks 0..DEPTH_WORDS-1 and writes 0 to one word per cycle. req_ready=0.
  - READY: req_ready=1.
- Reset values:
  - state = CLEAR (macro defined) or READY (macro undefined).
  - clear counter = 0.
  - rsp_valid = 0, rsp_rdata = 0, rsp_fault = 0.
  - req_ready = 0 while reset_n is low.
- Boundaries:
  - A store followed next cycle by a load to the same word returns the new data.
  - Asserting reset_n low mid-CLEAR restarts the clear from word 0.
  - Asserting reset_n low with a load in flight drops its response.
  - Last legal byte address DEPTH_WORDS*BYTES-1 with size=byte is legal.
  - Address 0 with size=dword on DATA_W=32 faults.

## Timing
- Request-to-response latency is exactly 1 cycle for loads, stores and faults.
- The response is valid for one cycle only; there is no response backpressure.
- Store data is visible to a load accepted at the following edge.
- With the macro, req_ready rises DEPTH_WORDS cycles after reset_n deasserts. Without it, req_ready rises at the first edge after deassertion.

## Configuration
- DATA_MEM_INIT_CLEAR_EN defined:
  - The CLEAR state exists.
  - All words read 0 after the clear completes.
  - req_ready is held low for DEPTH_WORDS cycles after reset.
- DATA_MEM_INIT_CLEAR_EN undefined:
  - No clear logic; memory contents after reset are undefined (infers plain RAM).
  - req_ready is high from the first edge after reset.

## Structure
- Package data_mem_pkg:
  - size enum SZ_B/SZ_H/SZ_W/SZ_D.
  - state enum CLEAR/READY.
  - function computing byte enables from size and lane.
- Sub-module data_mem_load_align: combinational shift, mask and extend of the registered word. Ports: word, lane, size, unsigned, out.
- The top level holds the storage array, FSM, clear counter and response registers.

## Test plan
- Reset with macro, DEPTH_WORDS=16:
  - req_ready stays 0 for 16 cycles, then rises to 1.
  - Load word at 0x3C → rsp_rdata 0x00000000, rsp_fault 0.
- Store word 0xDEADBEEF at 0x10, then load at 0x10 next cycle:
  - rsp_valid one cycle after the load is accepted.
  - rsp_rdata 0xDEADBEEF.
- Store byte 0x80 at 0x21, then:
  - Signed byte load at 0x21 → 0xFFFFFF80.
  - Unsigned byte load at 0x21 → 0x00000080.
  - Word load at 0x20 → 0x00008000 (from cleared memory).
- Halfword loads with the word at 0x30 holding 0x7FFF8001:
  - Halfword load at 0x32 → 0x00007FFF.
  - Signed halfword load at 0x30 → 0xFFFF8001.
- Faults:
  - Halfword load at 0x11 → rsp_fault 1, rsp_rdata 0.
  - Word store at 0x1000 with DEPTH_WORDS=1024 → rsp_fault 1, and memory is unchanged (verified by readback).
- Reset during CLEAR:
  - Assert reset_n low at clear count 5.
  - After release, req_ready stays low for a full DEPTH_WORDS cycles.
  - A stored-then-reset word reads 0.
